// File: rtl/program_mem_arbiter_pkg.sv
// Shared types and helpers for the program-memory arbiter and its picker.
package program_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITING  = 2'd1,
    RELAYING = 2'd2
  } arb_state_t;

  // Width of a grant index; kept at least 1 bit so a single-entry vector still has a legal index.
  function automatic int grant_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/program_mem_arbiter_if.sv
// Consumer-side and memory-side read channels of the program-memory arbiter.
interface program_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);

  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic                                    mem_read_valid;
  logic [ADDR_BITS-1:0]                    mem_read_address;
  logic                                    mem_read_ready;
  logic [DATA_BITS-1:0]                    mem_read_data;

  // Arbiter view.
  modport slave (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  // Environment view: fetchers plus program memory.
  modport master (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active request scanning upward from last_grant+1.
module rr_priority_picker
  import program_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 2,
  parameter int GRANT_BITS    = grant_bits(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req_i,
  input  logic [GRANT_BITS-1:0]    last_grant_i,
  output logic                     found_o,
  output logic [GRANT_BITS-1:0]    grant_o
);

  localparam int unsigned N = NUM_CONSUMERS;

  logic [31:0]           sum;
  logic [GRANT_BITS-1:0] idx;

  // Walk N positions after last_grant, wrapping, and keep the first requester seen.
  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      sum = 32'(last_grant_i) + i;
      idx = GRANT_BITS'(sum % N);
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among several fetchers.
module program_mem_arbiter
  import program_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input logic                  clk,
  input logic                  reset,
  program_mem_arbiter_if.slave bus
);

  localparam int GRANT_BITS = grant_bits(NUM_CONSUMERS);

  arb_state_t                              state_q;
  logic [GRANT_BITS-1:0]                   grant_q;
  logic [GRANT_BITS-1:0]                   last_grant_q;
  logic                                    mem_valid_q;
  logic [ADDR_BITS-1:0]                    mem_addr_q;
  logic [NUM_CONSUMERS-1:0]                ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;

  logic                  pick_found;
  logic [GRANT_BITS-1:0] pick_idx;

  rr_priority_picker #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .GRANT_BITS   (GRANT_BITS)
  ) u_picker (
    .req_i       (bus.consumer_read_valid),
    .last_grant_i(last_grant_q),
    .found_o     (pick_found),
    .grant_o     (pick_idx)
  );

  // Grant / wait-for-memory / relay-to-consumer sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_BITS'(NUM_CONSUMERS - 1);
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      ready_q      <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q     <= pick_idx;
            mem_addr_q  <= bus.consumer_read_address[pick_idx];
            mem_valid_q <= 1'b1;
            state_q     <= WAITING;
          end
        end
        WAITING: begin
          if (bus.mem_read_ready) begin
            mem_valid_q       <= 1'b0;
            data_q[grant_q]   <= bus.mem_read_data;
            ready_q[grant_q]  <= 1'b1;
            state_q           <= RELAYING;
          end
        end
        RELAYING: begin
          if (!bus.consumer_read_valid[grant_q]) begin
            ready_q[grant_q] <= 1'b0;
            last_grant_q     <= grant_q;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_address    = mem_addr_q;
  assign bus.consumer_read_ready = ready_q;
  assign bus.consumer_read_data  = data_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Directed bench for program_mem_arbiter with two consumers.
module tb_program_mem_arbiter;

  localparam int NC = 2;
  localparam int AB = 8;
  localparam int DB = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  program_mem_arbiter_if #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  program_mem_arbiter #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic mv, input logic [1:0] rdy);
    chk({tag, ".mem_valid"}, 32'(bus.mem_read_valid), 32'(mv));
    chk({tag, ".ready"}, 32'(bus.consumer_read_ready), 32'(rdy));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [DB-1:0] wd;
    int unsigned   g;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.consumer_read_valid   = '0;
    bus.consumer_read_address = '0;
    bus.mem_read_ready        = 1'b0;
    bus.mem_read_data         = '0;
    do_reset();

    // Reset state
    chk_outs("rst", 1'b0, 2'b00);
    chk("rst.addr", 32'(bus.mem_read_address), 32'h0);
    chk("rst.data0", 32'(bus.consumer_read_data[0]), 32'h0);
    chk("rst.data1", 32'(bus.consumer_read_data[1]), 32'h0);

    // Single request from consumer 1, memory answers two cycles later
    bus.consumer_read_valid[1]   = 1'b1;
    bus.consumer_read_address[1] = 8'h12;
    tick();
    chk_outs("t1.grant", 1'b1, 2'b00);
    chk("t1.addr", 32'(bus.mem_read_address), 32'h12);
    tick();
    chk_outs("t1.wait", 1'b1, 2'b00);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hBEEF;
    tick();
    chk_outs("t1.resp", 1'b0, 2'b10);
    chk("t1.data1", 32'(bus.consumer_read_data[1]), 32'hBEEF);
    chk("t1.data0", 32'(bus.consumer_read_data[0]), 32'h0);
    bus.mem_read_ready         = 1'b0;
    bus.consumer_read_valid[1] = 1'b0;
    tick();
    chk_outs("t1.done", 1'b0, 2'b00);

    // Both request from reset: grants alternate 0,1,0,1
    do_reset();
    bus.consumer_read_valid      = 2'b11;
    bus.consumer_read_address[0] = 8'h04;
    bus.consumer_read_address[1] = 8'h08;
    for (int t = 0; t < 4; t++) begin
      g  = (t % 2 == 0) ? 0 : 1;
      wd = 16'hA000 + 16'(t);
      tick();
      chk_outs("t2.grant", 1'b1, 2'b00);
      chk("t2.addr", 32'(bus.mem_read_address), (g == 0) ? 32'h04 : 32'h08);
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = wd;
      tick();
      chk_outs("t2.resp", 1'b0, (g == 0) ? 2'b01 : 2'b10);
      chk("t2.data", 32'(bus.consumer_read_data[g]), 32'(wd));
      bus.mem_read_ready         = 1'b0;
      bus.consumer_read_valid[g] = 1'b0;
      tick();
      chk_outs("t2.idle", 1'b0, 2'b00);
      bus.consumer_read_valid[g] = 1'b1;
    end
    chk("t2.final0", 32'(bus.consumer_read_data[0]), 32'hA002);
    chk("t2.final1", 32'(bus.consumer_read_data[1]), 32'hA003);

    // Consumer 0 holds valid 3 cycles after ready; consumer 1 requests meanwhile
    bus.consumer_read_valid = 2'b01;
    tick();
    chk("t3.addr", 32'(bus.mem_read_address), 32'h04);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h1111;
    tick();
    chk_outs("t3.resp", 1'b0, 2'b01);
    bus.mem_read_ready         = 1'b0;
    bus.consumer_read_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_outs("t3.hold", 1'b0, 2'b01);
    end
    bus.consumer_read_valid[0] = 1'b0;
    tick();
    chk_outs("t3.drop", 1'b0, 2'b00);
    tick();
    chk_outs("t3.next", 1'b1, 2'b00);
    chk("t3.next_addr", 32'(bus.mem_read_address), 32'h08);

    // Reset during WAITING, then both request: consumer 0 first again
    bus.consumer_read_valid[0] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_outs("t4.rst", 1'b0, 2'b00);
    chk("t4.data0", 32'(bus.consumer_read_data[0]), 32'h0);
    chk("t4.data1", 32'(bus.consumer_read_data[1]), 32'h0);
    tick();
    chk("t4.first_addr", 32'(bus.mem_read_address), 32'h04);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h2222;
    tick();
    chk_outs("t4.resp0", 1'b0, 2'b01);
    bus.mem_read_ready         = 1'b0;
    bus.consumer_read_valid[0] = 1'b0;
    tick();
    tick();
    chk_outs("t4.grant1", 1'b1, 2'b00);
    chk("t4.second_addr", 32'(bus.mem_read_address), 32'h08);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h3333;
    tick();
    chk_outs("t4.resp1", 1'b0, 2'b10);
    chk("t4.data1b", 32'(bus.consumer_read_data[1]), 32'h3333);
    bus.mem_read_ready      = 1'b0;
    bus.consumer_read_valid = 2'b00;
    tick();

    // Spurious mem_read_ready in IDLE, address change during WAITING
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h1234;
    tick();
    tick();
    chk_outs("t5.spur", 1'b0, 2'b00);
    chk("t5.spur_d0", 32'(bus.consumer_read_data[0]), 32'h2222);
    bus.mem_read_ready           = 1'b0;
    bus.consumer_read_valid[0]   = 1'b1;
    bus.consumer_read_address[0] = 8'h30;
    tick();
    chk("t5.addr", 32'(bus.mem_read_address), 32'h30);
    bus.consumer_read_address[0] = 8'h55;
    tick();
    chk_outs("t5.wait", 1'b1, 2'b00);
    chk("t5.addr_held", 32'(bus.mem_read_address), 32'h30);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h5A5A;
    tick();
    chk_outs("t5.resp", 1'b0, 2'b01);
    chk("t5.data0", 32'(bus.consumer_read_data[0]), 32'h5A5A);
    bus.mem_read_ready         = 1'b0;
    bus.consumer_read_valid[0] = 1'b0;
    tick();

    // Consumer 1 drops valid during WAITING
    bus.consumer_read_valid[1]   = 1'b1;
    bus.consumer_read_address[1] = 8'h77;
    tick();
    chk("t6.addr", 32'(bus.mem_read_address), 32'h77);
    bus.consumer_read_valid[1] = 1'b0;
    tick();
    chk_outs("t6.wait", 1'b1, 2'b00);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hC0DE;
    tick();
    chk_outs("t6.resp", 1'b0, 2'b10);
    chk("t6.data1", 32'(bus.consumer_read_data[1]), 32'hC0DE);
    bus.mem_read_ready = 1'b0;
    tick();
    chk_outs("t6.pulse_end", 1'b0, 2'b00);
    tick();
    chk_outs("t6.idle", 1'b0, 2'b00);
    chk("t6.data1_kept", 32'(bus.consumer_read_data[1]), 32'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_mem_arbiter.md
# program_mem_arbiter

Shares one program-memory read channel among NUM_CONSUMERS compute-core fetchers. The dual-core wrapper exposes one independent program read channel per core; this block sits between those channels and a single program memory port. It grants one pending fetch at a time in round-robin order, forwards its address, and relays the returned instruction word under the tiny-gpu valid/ready read handshake.

## Interface
Parameters:
- NUM_CONSUMERS, 2, number of fetch requesters (≥2)
- ADDR_BITS, 8, program memory address width
- DATA_BITS, 16, instruction word width

Ports:
- clk  in  1  the single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- consumer_read_valid  in  [NUM_CONSUMERS]  per-consumer fetch request
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  per-consumer fetch address
- consumer_read_ready  out  [NUM_CONSUMERS]  per-consumer data-available strobe
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  per-consumer returned word
- mem_read_valid  out  1  request to program memory
- mem_read_address  out  ADDR_BITS  address to program memory
- mem_read_ready  in  1  program memory has data
- mem_read_data  in  DATA_BITS  program memory word

## Operation
- Handshake, both sides: the requester raises valid with a stable address and holds both until it sees ready. It then drops valid. The responder drops ready after it sees valid low.
- State machine: IDLE, WAITING, RELAYING.
- IDLE:
  - If any consumer_read_valid is high, select the first requester scanning upward from (last_grant+1) mod NUM_CONSUMERS.
  - Latch the grant index g and consumer_read_address[g].
  - Set mem_read_valid=1 and mem_read_address=latched address.
  - Go to WAITING.
- WAITING:
  - Hold mem_read_valid and mem_read_address.
  - On mem_read_ready=1: set mem_read_valid=0, consumer_read_data[g]=mem_read_data, consumer_read_ready[g]=1, then go to RELAYING.
- RELAYING:
  - On consumer_read_valid[g]=0: set consumer_read_ready[g]=0, set last_grant=g, then go to IDLE.
  - Otherwise hold.
- Only the granted consumer ever sees ready high. All other consumer_read_ready bits stay 0.
- consumer_read_data[i] is registered and retained until the next completed grant to consumer i.
- The address is latched at grant. Address changes by the requester after grant are ignored.
- mem_read_ready is ignored in IDLE and RELAYING.
- A consumer that drops valid during WAITING is a protocol violation. The transaction still completes. RELAYING then exits on the next cycle because valid is already low.

## Timing
- Reset values: state=IDLE; mem_read_valid=0; mem_read_address=0; all consumer_read_ready=0; all consumer_read_data=0; last_grant=NUM_CONSUMERS-1, so consumer 0 wins first.
- Reset asserted mid-transaction clears everything at that edge. An in-flight memory read is abandoned, and mem_read_valid is low the following cycle.
- Latency:
  - Consumer valid sampled high in IDLE at edge k → mem_read_valid high after edge k.
  - mem_read_ready sampled at edge m → consumer_read_ready and data valid after edge m.
  - Consumer valid sampled low at edge n → ready low after edge n.
  - The next grant is issued no earlier than edge n+1. Minimum one IDLE cycle between transactions.
- Simultaneous requests are served strictly round-robin. With N=2 and both requesting continuously, grants alternate 0,1,0,1.
- Wrap-around: last_grant=N-1 scans from 0.

## Structure
- Shared package (program_mem_arbiter_pkg):
  - arb_state_t enum {IDLE, WAITING, RELAYING}
  - localparam GRANT_BITS = $clog2(NUM_CONSUMERS) convention
- Sub-module rr_priority_picker: combinational. Takes the request vector and last_grant. Outputs found flag and grant index. Reusable for the data-memory arbiter.
- Arbiter top holds the FSM, latched grant/address, and the per-consumer data and ready registers.

## Test plan
- Reset then single request: consumer 1 requests 0x12, memory answers 2 cycles later with 0xBEEF → mem_read_address=0x12, consumer_read_data[1]=0xBEEF, ready[1] high, ready[0] stays 0.
- Both request from reset (0x04, 0x08), both held continuously → grants in order 0,1,0,1. Memory addresses 0x04, 0x08 alternate. Each consumer receives its own data.
- Consumer holds valid 3 extra cycles after ready → ready[g] stays high and FSM stays RELAYING until valid drops. No new mem_read_valid in that window.
- Reset asserted during WAITING → next cycle mem_read_valid=0, all ready=0, all data=0. A later request from consumer 1 is still granted after consumer 0's if both request (last_grant reset to N-1).
- Spurious mem_read_ready in IDLE and a requester address change during WAITING → no ready to any consumer. Memory address stays the latched value.
- Consumer drops valid during WAITING → transaction completes, ready[g] pulses for exactly one cycle, FSM returns to IDLE.
